// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing source for the draw_* pipeline (800x600@60 at 40 MHz by default).
// Latency: all outputs registered; flags are decoded from next-state counts, so they line up with counts.
// Backpressure: none; en=0 freezes every output and masks frame_start.
//
// Ports:
//   pclk, reset (sync, active-high), en       - clock, reset, count enable
//   hcount_out/vcount_out [11:0]              - pixel / line index
//   hsync_out/vsync_out                       - syncs, polarity set by SYNC_POL
//   hblnk_out/vblnk_out                       - blanking, always active-high
//   frame_start                               - one-cycle pulse when counts become (0,0)
//   frame_cnt [15:0]                          - frames completed since reset, wrapping
module vga_timing_gen #(
  parameter int H_VISIBLE    = 800,
  parameter int H_SYNC_START = 840,
  parameter int H_SYNC_END   = 968,
  parameter int H_TOTAL      = 1056,
  parameter int V_VISIBLE    = 600,
  parameter int V_SYNC_START = 601,
  parameter int V_SYNC_END   = 605,
  parameter int V_TOTAL      = 628,
  parameter bit SYNC_POL     = 1'b1
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        en,
  output logic [11:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [11:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  if (!(H_VISIBLE <= H_SYNC_START && H_SYNC_START < H_SYNC_END && H_SYNC_END <= H_TOTAL))
  begin : g_bad_h_timing
    $error("vga_timing_gen: horizontal timing parameters out of order");
  end
  if (!(V_VISIBLE <= V_SYNC_START && V_SYNC_START < V_SYNC_END && V_SYNC_END <= V_TOTAL))
  begin : g_bad_v_timing
    $error("vga_timing_gen: vertical timing parameters out of order");
  end

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS  = 12'(H_VISIBLE);
  localparam logic [11:0] H_SS   = 12'(H_SYNC_START);
  localparam logic [11:0] H_SE   = 12'(H_SYNC_END);
  localparam logic [11:0] V_VIS  = 12'(V_VISIBLE);
  localparam logic [11:0] V_SS   = 12'(V_SYNC_START);
  localparam logic [11:0] V_SE   = 12'(V_SYNC_END);
  // Sync level driven when outside the sync window.
  localparam logic SYNC_IDLE = ~SYNC_POL;

  logic [11:0] hcount_q, hcount_d;
  logic [11:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        line_end, frame_end;

  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    frame_cnt_d   = frame_cnt_q;
    frame_start_d = 1'b0;
    line_end      = (hcount_q == H_LAST);
    frame_end     = line_end && (vcount_q == V_LAST);
    if (en) begin
      hcount_d = line_end ? 12'd0 : hcount_q + 12'd1;
      if (line_end) begin
        vcount_d = (vcount_q == V_LAST) ? 12'd0 : vcount_q + 12'd1;
      end
      frame_start_d = frame_end;
      frame_cnt_d   = frame_cnt_q + {15'd0, frame_end};
    end
    // Decoding from the next-state counts keeps flags aligned with the counts they describe.
    // With en=0 the counts hold, so these decode to the held flag values.
    hblnk_d = (hcount_d >= H_VIS);
    vblnk_d = (vcount_d >= V_VIS);
    hsync_d = ((hcount_d >= H_SS) && (hcount_d < H_SE)) ^ SYNC_IDLE;
    vsync_d = ((vcount_d >= V_SS) && (vcount_d < V_SE)) ^ SYNC_IDLE;
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      hcount_q      <= 12'd0;
      vcount_q      <= 12'd0;
      hsync_q       <= SYNC_IDLE;
      vsync_q       <= SYNC_IDLE;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 16'd0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign hcount_out  = hcount_q;
  assign vcount_out  = vcount_q;
  assign hsync_out   = hsync_q;
  assign vsync_out   = vsync_q;
  assign hblnk_out   = hblnk_q;
  assign vblnk_out   = vblnk_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance for line-level timing, and a
// reduced-geometry, inverted-sync instance so whole frames fit in a short run.
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_vga_timing_gen;

  logic        pclk;
  logic        reset_a, en_a, reset_b, en_b;

  logic [11:0] hc_a, vc_a, hc_b, vc_b;
  logic        hs_a, vs_a, hb_a, vb_a, fs_a;
  logic        hs_b, vs_b, hb_b, vb_b, fs_b;
  logic [15:0] fc_a, fc_b;

  int checks;
  int errors;

  // Reduced geometry for instance B
  localparam int BH_VIS = 16, BH_SS = 18, BH_SE = 21, BH_TOT = 24;
  localparam int BV_VIS = 8,  BV_SS = 9,  BV_SE = 11, BV_TOT = 13;

  vga_timing_gen u_dut_a (
    .pclk(pclk), .reset(reset_a), .en(en_a),
    .hcount_out(hc_a), .hsync_out(hs_a), .hblnk_out(hb_a),
    .vcount_out(vc_a), .vsync_out(vs_a), .vblnk_out(vb_a),
    .frame_start(fs_a), .frame_cnt(fc_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(BH_VIS), .H_SYNC_START(BH_SS), .H_SYNC_END(BH_SE), .H_TOTAL(BH_TOT),
    .V_VISIBLE(BV_VIS), .V_SYNC_START(BV_SS), .V_SYNC_END(BV_SE), .V_TOTAL(BV_TOT),
    .SYNC_POL(1'b0)
  ) u_dut_b (
    .pclk(pclk), .reset(reset_b), .en(en_b),
    .hcount_out(hc_b), .hsync_out(hs_b), .hblnk_out(hb_b),
    .vcount_out(vc_b), .vsync_out(vs_b), .vblnk_out(vb_b),
    .frame_start(fs_b), .frame_cnt(fc_b)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge pclk);
  endtask

  // Full-state check of instance B against a raster position (inverted syncs)
  task automatic chk_b(input string tag, input int h, input int v, input int fs, input int fc);
    chk({tag, ".hcount"}, 32'(hc_b), 32'(h));
    chk({tag, ".vcount"}, 32'(vc_b), 32'(v));
    chk({tag, ".hsync"},  32'(hs_b), 32'(!(h >= BH_SS && h < BH_SE)));
    chk({tag, ".vsync"},  32'(vs_b), 32'(!(v >= BV_SS && v < BV_SE)));
    chk({tag, ".hblnk"},  32'(hb_b), 32'(h >= BH_VIS));
    chk({tag, ".vblnk"},  32'(vb_b), 32'(v >= BV_VIS));
    chk({tag, ".fstart"}, 32'(fs_b), 32'(fs));
    chk({tag, ".fcnt"},   32'(fc_b), 32'(fc));
  endtask

  initial begin
    int hs_cycles;
    int blnk_rise;
    checks    = 0;
    errors    = 0;
    hs_cycles = 0;
    blnk_rise = -1;

    reset_a = 1'b1; en_a = 1'b1;
    reset_b = 1'b1; en_b = 1'b0;   // B stays frozen at (0,0) until its phase
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    reset_a = 1'b0; reset_b = 1'b0;

    // Reset state, instance A (active-high syncs idle low)
    chk("rst.hcount", 32'(hc_a), 0);
    chk("rst.vcount", 32'(vc_a), 0);
    chk("rst.hsync",  32'(hs_a), 0);
    chk("rst.vsync",  32'(vs_a), 0);
    chk("rst.hblnk",  32'(hb_a), 0);
    chk("rst.vblnk",  32'(vb_a), 0);
    chk("rst.fstart", 32'(fs_a), 0);
    chk("rst.fcnt",   32'(fc_a), 0);

    // One full line of instance A
    for (int h = 0; h < 1056; h++) begin
      chk("line.hcount", 32'(hc_a), 32'(h));
      chk("line.vcount", 32'(vc_a), 0);
      chk("line.hblnk",  32'(hb_a), 32'(h >= 800));
      chk("line.hsync",  32'(hs_a), 32'(h >= 840 && h < 968));
      chk("line.vsync",  32'(vs_a), 0);
      chk("line.fstart", 32'(fs_a), 0);
      if (hs_a) hs_cycles++;
      if (hb_a && blnk_rise < 0) blnk_rise = h;
      step(1);
    end
    chk("line.hsync_width", 32'(hs_cycles), 128);
    chk("line.hblnk_rise",  32'(blnk_rise), 800);
    chk("line.wrap_h", 32'(hc_a), 0);
    chk("line.wrap_v", 32'(vc_a), 1);

    // Line wrap at (1055,5)
    step(4 * 1056 + 1055);
    chk("wrap5.hcount", 32'(hc_a), 1055);
    chk("wrap5.vcount", 32'(vc_a), 5);
    chk("wrap5.hblnk",  32'(hb_a), 1);
    step(1);
    chk("wrap6.hcount", 32'(hc_a), 0);
    chk("wrap6.vcount", 32'(vc_a), 6);
    chk("wrap6.hblnk",  32'(hb_a), 0);
    chk("wrap6.vblnk",  32'(vb_a), 0);

    // Enable hold at hcount=300
    step(300);
    chk("hold.start", 32'(hc_a), 300);
    en_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("hold.hcount", 32'(hc_a), 300);
      chk("hold.vcount", 32'(vc_a), 6);
      chk("hold.hblnk",  32'(hb_a), 0);
      chk("hold.fstart", 32'(fs_a), 0);
      chk("hold.fcnt",   32'(fc_a), 0);
    end
    en_a = 1'b1;
    step(1);
    chk("resume.hcount", 32'(hc_a), 301);
    chk("resume.vcount", 32'(vc_a), 6);
    en_a = 1'b0;

    // Instance B: reset state with inverted syncs idling high
    chk_b("b.rst", 0, 0, 0, 0);
    en_b = 1'b1;
    // Whole first frame, position by position
    for (int k = 0; k < BH_TOT * BV_TOT; k++) begin
      chk_b("b.frame1", k % BH_TOT, k / BH_TOT, 0, 0);
      step(1);
    end
    chk_b("b.wrap1", 0, 0, 1, 1);
    // en low while frame_start is high: pulse must drop, counts hold
    en_b = 1'b0;
    step(1);
    chk_b("b.hold", 0, 0, 0, 1);
    en_b = 1'b1;
    step(1);
    chk_b("b.resume", 1, 0, 0, 1);
    // Second wrap after a full period (one held cycle was already spent)
    step(BH_TOT * BV_TOT - 2);
    chk_b("b.prewrap2", BH_TOT - 1, BV_TOT - 1, 0, 1);
    step(1);
    chk_b("b.wrap2", 0, 0, 1, 2);
    step(1);
    chk_b("b.post2", 1, 0, 0, 2);

    // Reset mid-frame inside both sync windows
    step(BV_SS * BH_TOT + 19);
    chk_b("b.mid", 20, 9, 0, 2);
    reset_b = 1'b1;
    step(1);
    chk_b("b.reset", 0, 0, 0, 0);
    reset_b = 1'b0;
    step(1);
    chk_b("b.after_rst", 1, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
